psum_deskew_drain: RTL

//  Output stage of the MAC-based systolic cube. It consumes the skewed o_y_p psums leaving the

---
 rtl/psum_deskew_drain.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/psum_deskew_drain.sv
// Output stage of the systolic cube: de-skews the bottom-row psums, requantizes each aligned row
// and queues it in a small FIFO that drains through a valid/ready port.
module psum_deskew_drain #(
  parameter int COLS      = 4,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT_W   = 5,
  parameter int DEPTH     = 4,
  parameter int ROWS_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [ROWS_W-1:0]         i_rows,
  input  logic [SHIFT_W-1:0]        i_shift,
  input  logic [COLS*ACC_WIDTH-1:0] i_y_p,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [COLS*OUT_WIDTH-1:0] o_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int K_W    = ROWS_W + $clog2(COLS) + 1;
  localparam int EXT_W  = ACC_WIDTH + (1 << SHIFT_W) + 1;
  localparam int ROW_W  = COLS * OUT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ROWS_W-1:0]   rows_q, rows_d;
  logic [SHIFT_W-1:0]  sh_q, sh_d;
  logic                ov_q, ov_d;
  logic                done_q, done_d;
  logic                rq_valid_q, rq_valid_d;
  logic [ROW_W-1:0]    rq_data_q, rq_data_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0]    data_q, data_d;
  logic [ROW_W-1:0]    mem_q [DEPTH];
  logic [ROW_W-1:0]    mem_d [DEPTH];
  logic [ROW_W-1:0]    head_d;
  logic [COLS*ACC_WIDTH-1:0] aligned;
  logic [K_W-1:0]      last_k;
  logic                pop, wr_en, drop;

  // Lane c waits COLS-1-c cycles so every lane of a row lines up with the last column.
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c*ACC_WIDTH +: ACC_WIDTH] = i_y_p[c*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] dly_q [D];
      logic [ACC_WIDTH-1:0] dly_d [D];
      always_comb begin
        dly_d[0] = i_y_p[c*ACC_WIDTH +: ACC_WIDTH];
        for (int s = 1; s < D; s++) dly_d[s] = dly_q[s-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < D; s++) dly_q[s] <= '0;
        end else begin
          for (int s = 0; s < D; s++) dly_q[s] <= dly_d[s];
        end
      end
      assign aligned[c*ACC_WIDTH +: ACC_WIDTH] = dly_q[D-1];
    end
  end

  // Round-half-up arithmetic shift, then clamp to the signed output range.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] x,
                                                   input logic [SHIFT_W-1:0]   sh);
    logic signed [EXT_W-1:0] xe;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] v;
    logic signed [EXT_W-1:0] max_v;
    logic signed [EXT_W-1:0] min_v;
    xe    = {{(EXT_W-ACC_WIDTH){x[ACC_WIDTH-1]}}, x};
    rnd   = '0;
    if (sh != '0) rnd = EXT_W'(1) << (sh - SHIFT_W'(1));
    v     = (xe + rnd) >>> sh;
    max_v = (EXT_W'(1) << (OUT_WIDTH - 1)) - EXT_W'(1);
    min_v = -max_v - EXT_W'(1);
    if (v > max_v)      requant = max_v[OUT_WIDTH-1:0];
    else if (v < min_v) requant = min_v[OUT_WIDTH-1:0];
    else                requant = v[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    rq_data_d = '0;
    for (int c = 0; c < COLS; c++) begin
      rq_data_d[c*OUT_WIDTH +: OUT_WIDTH] = requant(aligned[c*ACC_WIDTH +: ACC_WIDTH], sh_q);
    end
  end

  // o_valid/i_ready: the head leaves on every cycle with o_valid & i_ready; while o_valid is
  // high and i_ready low the head and o_data hold. The array never stalls, so a write that
  // finds the FIFO full (and no pop that cycle) drops the row and sets the sticky overflow.
  always_comb begin
    pop      = (cnt_q != '0) && i_ready;
    wr_en    = rq_valid_q && ((cnt_q != CNT_W'(DEPTH)) || pop);
    drop     = rq_valid_q && !wr_en;
    wr_ptr_d = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = rq_data_q;
    head_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? rq_data_q : mem_q[rd_ptr_d];
    data_d = (cnt_d != '0) ? head_d : data_q;
  end

  // k counts cycles since the start pulse; aligned row r appears at k = r + COLS - 1.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    rows_d     = rows_q;
    sh_d       = sh_q;
    ov_d       = ov_q;
    rq_valid_d = 1'b0;
    last_k     = K_W'(rows_q) + K_W'(COLS - 2);
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          rows_d  = i_rows;
          sh_d    = i_shift;
          ov_d    = 1'b0;
          k_d     = K_W'(1);
          state_d = (i_rows == '0) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        k_d = k_q + K_W'(1);
        if (k_q >= K_W'(COLS - 1)) rq_valid_d = 1'b1;
        if (k_q == last_k) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!rq_valid_q && (cnt_q == '0)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (drop) ov_d = 1'b1;
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      rows_q     <= '0;
      sh_q       <= '0;
      ov_q       <= 1'b0;
      done_q     <= 1'b0;
      rq_valid_q <= 1'b0;
      rq_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      rows_q     <= rows_d;
      sh_q       <= sh_d;
      ov_q       <= ov_d;
      done_q     <= done_d;
      rq_valid_q <= rq_valid_d;
      rq_data_q  <= rq_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign o_valid    = (cnt_q != '0);
  assign o_data     = data_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;
  assign o_overflow = ov_q;

endmodule
